puf_eval_ctrl: RTL

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

---
 rtl/puf_pkg.sv | 16 +
 rtl/puf_majority3.sv | 13 +
 rtl/puf_eval_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF evaluation block.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SAMPLE,
        DONE
    } puf_state_t;

    localparam int DEFAULT_WINDOW = 240;
    localparam int DEFAULT_RESP_W = 16;
    localparam int PASSES         = 3;

endpackage

// File: rtl/puf_majority3.sv
// Bitwise 2-of-3 vote across three PUF response samples.
module puf_majority3 #(
    parameter int W = 16
) (
    input  logic [0:W-1] a,
    input  logic [0:W-1] b,
    input  logic [0:W-1] c,
    output logic [0:W-1] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/puf_eval_ctrl.sv
// RO PUF evaluation sequencer: clear, count window, sample, hand off.
// Build with PUF_MAJORITY_VOTE_EN for three passes and a 2-of-3 vote.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int RESP_W = DEFAULT_RESP_W
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            start,
    input  logic            abort,
    input  logic [0:RESP_W-1] resp_in,
    input  logic            ack,
    output logic            ro_en,
    output logic            cnt_clr,
    output logic [0:7]      count,
    output logic            busy,
    output logic            valid,
    output logic [0:RESP_W-1] response
);

    localparam logic [0:7] WIN = 8'(WINDOW);

    puf_state_t        state;
    logic              last_pass;
    logic [0:RESP_W-1] final_resp;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]        pass_idx;
    logic [0:RESP_W-1] pass0;
    logic [0:RESP_W-1] pass1;

    // Third pass is voted directly from resp_in, so only two are stored.
    puf_majority3 #(
        .W(RESP_W)
    ) u_vote (
        .a(pass0),
        .b(pass1),
        .c(resp_in),
        .y(final_resp)
    );

    assign last_pass = (pass_idx == 2'(PASSES - 1));
`else
    assign final_resp = resp_in;
    assign last_pass  = 1'b1;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            ro_en    <= 1'b0;
            cnt_clr  <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            response <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_idx <= '0;
            pass0    <= '0;
            pass1    <= '0;
`endif
        end else if (abort && state inside {CLEAR, RUN, SAMPLE}) begin
            state   <= IDLE;
            ro_en   <= 1'b0;
            cnt_clr <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_idx <= '0;
            pass0    <= '0;
            pass1    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                        count   <= '0;
                    end
                end
                CLEAR: begin
                    state   <= RUN;
                    cnt_clr <= 1'b0;
                    ro_en   <= 1'b1;
                    count   <= '0;
                end
                RUN: begin
                    if (count == WIN) begin
                        state <= SAMPLE;
                        ro_en <= 1'b0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (last_pass) begin
                        state    <= DONE;
                        valid    <= 1'b1;
                        count    <= '0;
                        response <= final_resp;
`ifdef PUF_MAJORITY_VOTE_EN
                        pass_idx <= '0;
`endif
                    end else begin
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                        count   <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
                        if (pass_idx == 2'd0) pass0 <= resp_in;
                        else                  pass1 <= resp_in;
                        pass_idx <= pass_idx + 2'd1;
`endif
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ro_en <= 1'b0;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
